// File: rtl/mvau_fold_ctrl.sv
// mvau_fold_ctrl: fold sequencer for one MVAU matrix-vector pass.
//
// Walks SF synapse folds inside each of NF neuron folds. Fold 0 consumes beats
// straight from the input stream and writes them into the input buffer. Later
// folds replay the buffer. Each issued beat produces a weight address and an
// input-buffer address, plus one-cycle-late do_mvau_stream/sf_clr strobes to
// the PE array. After the last beat the block waits for the datapath to drain
// and then pulses done.
//
// Optional build macro MVAU_FOLD_CTRL_PERF_EN adds two 32-bit saturating
// counters, stall_cnt and beat_cnt, for performance monitoring.

module mvau_fold_ctrl #(
  parameter int unsigned SF       = 4,
  parameter int unsigned NF       = 2,
  parameter int unsigned PIPE_DLY = 2,
  parameter int unsigned WA_W     = (SF * NF > 1) ? $clog2(SF * NF) : 1,
  parameter int unsigned IA_W     = (SF > 1) ? $clog2(SF) : 1
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            start,
  input  logic            in_v,
  output logic            in_rdy,
  input  logic            out_rdy,
  output logic            do_mvau_stream,
  output logic            sf_clr,
  output logic [WA_W-1:0] wmem_addr,
  output logic [IA_W-1:0] ib_addr,
  output logic            ib_wen,
  output logic            busy,
  output logic            done
`ifdef MVAU_FOLD_CTRL_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     beat_cnt
`endif
);

  localparam int unsigned NaW    = (NF > 1) ? $clog2(NF) : 1;
  // Drain covers the do_mvau_stream register stage plus PIPE_DLY+1 datapath
  // cycles, so done lands PIPE_DLY+2 cycles after the final do_mvau_stream.
  localparam int unsigned DrainW = $clog2(PIPE_DLY + 2);

  localparam logic [IA_W-1:0]   SfLast    = IA_W'(SF - 1);
  localparam logic [NaW-1:0]    NfLast    = NaW'(NF - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(PIPE_DLY + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IA_W-1:0]   sf_cnt_q, sf_cnt_d;
  logic [NaW-1:0]    nf_cnt_q, nf_cnt_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic              dv_q;
  logic              clr_q;
  logic              done_q, done_d;

  logic run;
  logic fold0;
  logic beat;
  logic sf_last;
  logic nf_last;
  logic start_ok;

  // Beat qualification: fold 0 needs a stream beat, later folds only downstream room.
  always_comb begin
    run      = (state_q == StRun);
    fold0    = (nf_cnt_q == '0);
    sf_last  = (sf_cnt_q == SfLast);
    nf_last  = (nf_cnt_q == NfLast);
    beat     = run & out_rdy & (fold0 ? in_v : 1'b1);
    // The done cycle still closes the previous pass; a new start counts from the next cycle.
    start_ok = (state_q == StIdle) & start & ~done_q;
  end

  // Next-state logic for the pass FSM and the fold counters.
  always_comb begin
    state_d     = state_q;
    sf_cnt_d    = sf_cnt_q;
    nf_cnt_d    = nf_cnt_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (beat) begin
          if (sf_last) begin
            sf_cnt_d = '0;
            if (nf_last) begin
              nf_cnt_d = '0;
              state_d  = StDrain;
            end else begin
              nf_cnt_d = nf_cnt_q + NaW'(1);
            end
          end else begin
            sf_cnt_d = sf_cnt_q + IA_W'(1);
          end
        end
      end
      StDrain: begin
        if (drain_cnt_q == DrainLast) begin
          drain_cnt_d = '0;
          state_d     = StIdle;
          done_d      = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + DrainW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers and the one-cycle-late PE strobes; reset aborts any pass.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= StIdle;
      sf_cnt_q    <= '0;
      nf_cnt_q    <= '0;
      drain_cnt_q <= '0;
      dv_q        <= 1'b0;
      clr_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sf_cnt_q    <= sf_cnt_d;
      nf_cnt_q    <= nf_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      dv_q        <= beat;
      clr_q       <= beat & sf_last;
      done_q      <= done_d;
    end
  end

  // Output decode; addresses track the counters so they are valid in the issue cycle.
  always_comb begin
    in_rdy         = run & fold0 & out_rdy;
    ib_wen         = in_v & in_rdy;
    wmem_addr      = WA_W'(nf_cnt_q) * WA_W'(SF) + WA_W'(sf_cnt_q);
    ib_addr        = sf_cnt_q;
    busy           = (state_q == StRun) | (state_q == StDrain);
    do_mvau_stream = dv_q;
    sf_clr         = clr_q;
    done           = done_q;
  end

`ifdef MVAU_FOLD_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] beat_cnt_q;

  // Saturating monitors; cleared by an accepted start, frozen outside RUN.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stall_cnt_q <= '0;
      beat_cnt_q  <= '0;
    end else if (start_ok) begin
      stall_cnt_q <= '0;
      beat_cnt_q  <= '0;
    end else if (run) begin
      if (beat) begin
        if (beat_cnt_q != '1) begin
          beat_cnt_q <= beat_cnt_q + 32'd1;
        end
      end else if (stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign beat_cnt  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_mvau_fold_ctrl.sv
// Self-checking bench for mvau_fold_ctrl. Two instances share the stimulus:
// SF=4/NF=2 and SF=1/NF=3. The reference model tracks each pass as a linear
// beat index k (0..SF*NF-1) plus a cycle count since the final beat.

module tb_mvau_fold_ctrl;

  localparam int PD = 2;

  logic aclk = 1'b0;
  logic aresetn, start, in_v, out_rdy;

  logic       rdy0, dv0, clr0, wen0, busy0, done0;
  logic [2:0] wa0;
  logic [1:0] ia0;
  logic       rdy1, dv1, clr1, wen1, busy1, done1;
  logic [1:0] wa1;
  logic [0:0] ia1;
`ifdef MVAU_FOLD_CTRL_PERF_EN
  logic [31:0] stall0, beats0, stall1, beats1;
`endif

  always #5 aclk = ~aclk;

  mvau_fold_ctrl #(.SF(4), .NF(2), .PIPE_DLY(PD)) u_dut0 (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .start          (start),
    .in_v           (in_v),
    .in_rdy         (rdy0),
    .out_rdy        (out_rdy),
    .do_mvau_stream (dv0),
    .sf_clr         (clr0),
    .wmem_addr      (wa0),
    .ib_addr        (ia0),
    .ib_wen         (wen0),
    .busy           (busy0),
    .done           (done0)
`ifdef MVAU_FOLD_CTRL_PERF_EN
    ,
    .stall_cnt      (stall0),
    .beat_cnt       (beats0)
`endif
  );

  mvau_fold_ctrl #(.SF(1), .NF(3), .PIPE_DLY(PD)) u_dut1 (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .start          (start),
    .in_v           (in_v),
    .in_rdy         (rdy1),
    .out_rdy        (out_rdy),
    .do_mvau_stream (dv1),
    .sf_clr         (clr1),
    .wmem_addr      (wa1),
    .ib_addr        (ia1),
    .ib_wen         (wen1),
    .busy           (busy1),
    .done           (done1)
`ifdef MVAU_FOLD_CTRL_PERF_EN
    ,
    .stall_cnt      (stall1),
    .beat_cnt       (beats1)
`endif
  );

  int total = 0;
  int bad   = 0;
  int ndone = 0;

  // Reference model state per instance.
  bit m_act   [2];
  int m_k     [2];
  int m_after [2];
  bit m_dv    [2];
  bit m_clr   [2];
  bit m_done  [2];
  int m_stall [2];
  int m_beats [2];

  function automatic int sf_of(input int c);
    return (c == 0) ? 4 : 1;
  endfunction

  function automatic int nf_of(input int c);
    return (c == 0) ? 2 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_act[c]   = 1'b0;
      m_k[c]     = 0;
      m_after[c] = 0;
      m_dv[c]    = 1'b0;
      m_clr[c]   = 1'b0;
      m_done[c]  = 1'b0;
      m_stall[c] = 0;
      m_beats[c] = 0;
    end
  endtask

  // Check every output of both instances against the model, then advance one cycle.
  task automatic step();
    logic [31:0] obs [2][8];
    logic [31:0] ex  [8];
    string nm [8] = '{"in_rdy", "ib_wen", "wmem_addr", "ib_addr", "do_mvau_stream",
                      "sf_clr", "busy", "done"};
    bit beat [2];
    bit run;
    bit nd;
    int sf, nf, wa;
    @(negedge aclk);
    obs[0] = '{32'(rdy0), 32'(wen0), 32'(wa0), 32'(ia0), 32'(dv0), 32'(clr0), 32'(busy0),
               32'(done0)};
    obs[1] = '{32'(rdy1), 32'(wen1), 32'(wa1), 32'(ia1), 32'(dv1), 32'(clr1), 32'(busy1),
               32'(done1)};
    for (int c = 0; c < 2; c++) begin
      sf      = sf_of(c);
      nf      = nf_of(c);
      run     = m_act[c] && (m_k[c] < sf * nf);
      beat[c] = run && (out_rdy === 1'b1) && ((m_k[c] < sf) ? (in_v === 1'b1) : 1'b1);
      wa      = run ? m_k[c] : 0;
      ex[0]   = 32'(run && (m_k[c] < sf) && (out_rdy === 1'b1));
      ex[1]   = 32'(run && (m_k[c] < sf) && (out_rdy === 1'b1) && (in_v === 1'b1));
      ex[2]   = 32'(wa);
      ex[3]   = 32'(wa % sf);
      ex[4]   = 32'(m_dv[c]);
      ex[5]   = 32'(m_clr[c]);
      ex[6]   = 32'(m_act[c]);
      ex[7]   = 32'(m_done[c]);
      for (int j = 0; j < 8; j++) begin
        chk($sformatf("%s[%0d]", nm[j], c), obs[c][j], ex[j]);
      end
    end
    if (done0 === 1'b1) ndone++;
    for (int c = 0; c < 2; c++) begin
      sf = sf_of(c);
      nf = nf_of(c);
      if (aresetn !== 1'b1) begin
        m_act[c]   = 1'b0;
        m_k[c]     = 0;
        m_after[c] = 0;
        m_dv[c]    = 1'b0;
        m_clr[c]   = 1'b0;
        m_done[c]  = 1'b0;
        m_stall[c] = 0;
        m_beats[c] = 0;
      end else begin
        nd       = 1'b0;
        m_dv[c]  = beat[c];
        m_clr[c] = beat[c] && ((m_k[c] % sf) == sf - 1);
        if (!m_act[c] && !m_done[c] && (start === 1'b1)) begin
          m_act[c]   = 1'b1;
          m_k[c]     = 0;
          m_after[c] = 0;
          m_stall[c] = 0;
          m_beats[c] = 0;
        end else if (m_act[c]) begin
          if (beat[c]) begin
            m_k[c]++;
            m_beats[c]++;
            if (m_k[c] == sf * nf) m_after[c] = 1;
          end else if (m_k[c] < sf * nf) begin
            m_stall[c]++;
          end else begin
            m_after[c]++;
            if (m_after[c] == PD + 3) begin
              m_act[c] = 1'b0;
              nd       = 1'b1;
            end
          end
        end
        m_done[c] = nd;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  // Mode 0 clean, 1 in_v gap after beat 2, 2 out_rdy gap in fold 1, 3 random + stray starts.
  task automatic run_pass(input int mode);
    int gap;
    bit fin;
    gap   = 0;
    fin   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      start   = (i == 0) || (mode == 3 && $urandom_range(0, 7) == 0);
      in_v    = 1'b1;
      out_rdy = 1'b1;
      case (mode)
        1: if (m_k[0] == 2 && m_act[0] && gap < 3) begin in_v = 1'b0; gap++; end
        2: if (m_k[0] == 5 && m_act[0] && gap < 2) begin out_rdy = 1'b0; gap++; end
        3: begin
          in_v    = ($urandom_range(0, 3) != 0);
          out_rdy = ($urandom_range(0, 3) != 0);
        end
        default: ;
      endcase
      step();
      fin = m_done[0];
    end
    chk("pass_finished", 32'(m_done[0]), 32'd1);
    start   = 1'b0;
    in_v    = 1'b0;
    out_rdy = 1'b0;
    step();
    chk("done_count", 32'(ndone), 32'd1);
`ifdef MVAU_FOLD_CTRL_PERF_EN
    chk("beat_cnt", beats0, 32'd8);
    chk("beat_cnt_model", beats0, 32'(m_beats[0]));
    chk("stall_cnt_model", stall0, 32'(m_stall[0]));
    if (mode == 1) chk("stall_cnt_inj", stall0, 32'd3);
    if (mode == 2) chk("stall_cnt_inj", stall0, 32'd2);
    if (mode == 0) chk("stall_cnt_inj", stall0, 32'd0);
`endif
  endtask

  initial begin
    aresetn = 1'b0;
    start   = 1'b0;
    in_v    = 1'b0;
    out_rdy = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    model_reset();
    step();
    aresetn = 1'b1;

    run_pass(0);
    run_pass(1);
    run_pass(2);

    // Abort in the middle of fold 1, then make sure nothing else happens.
    ndone   = 0;
    start   = 1'b1;
    in_v    = 1'b1;
    out_rdy = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("mid_fold1_k", 32'(m_k[0]), 32'd6);
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("no_done_after_reset", 32'(ndone), 32'd0);

    run_pass(0);
    for (int p = 0; p < 6; p++) run_pass(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
